// File: rtl/movement_executor.sv
// Differential-drive motion executor: latches one command, drives both motors
// for a fixed number of prescaled ticks with PWM-gated enables, then pulses done.
module movement_executor #(
  parameter int CLK_DIV    = 16,
  parameter int MOVE_TICKS = 8,
  parameter int DUTY       = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] movement_sel,
  output logic       motor_l_en,
  output logic       motor_l_dir,
  output logic       motor_r_en,
  output logic       motor_r_dir,
  output logic       busy,
  output logic       done,
  output logic       cmd_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [15:0] PRESC_MAX = 16'(CLK_DIV - 1);
  localparam logic [7:0]  TICK_MAX  = 8'(MOVE_TICKS - 1);
  localparam logic [4:0]  DUTY_C    = 5'(DUTY);

  state_t     state;
  logic [3:0] cmd_q;
  logic [15:0] presc;
  logic [7:0] tick;
  logic [3:0] pwm_cnt;
  logic [3:0] pwm_nxt;

  assign pwm_nxt = pwm_cnt + 4'd1;

  // {l_dir, r_dir} for each legal command code
  function automatic logic [1:0] dir_of(input logic [3:0] c);
    case (c)
      4'd1:    return 2'b11;
      4'd2:    return 2'b00;
      4'd3:    return 2'b10;
      4'd4:    return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cmd_q       <= 4'd0;
      presc       <= 16'd0;
      tick        <= 8'd0;
      pwm_cnt     <= 4'd0;
      motor_l_en  <= 1'b0;
      motor_r_en  <= 1'b0;
      motor_l_dir <= 1'b0;
      motor_r_dir <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      done    <= 1'b0;
      cmd_err <= 1'b0;
      case (state)
        IDLE: begin
          motor_l_en <= 1'b0;
          motor_r_en <= 1'b0;
          busy       <= 1'b0;
          if (movement_sel inside {[4'd1:4'd4]}) begin
            // Outputs are loaded on the entry edge so RUN cycle 0 already drives
            state      <= RUN;
            cmd_q      <= movement_sel;
            presc      <= 16'd0;
            tick       <= 8'd0;
            pwm_cnt    <= 4'd0;
            busy       <= 1'b1;
            motor_l_en <= (5'd0 < DUTY_C);
            motor_r_en <= (5'd0 < DUTY_C);
            {motor_l_dir, motor_r_dir} <= dir_of(movement_sel);
          end else if (movement_sel != 4'd0) begin
            cmd_err <= 1'b1;
          end
        end
        RUN: begin
          pwm_cnt    <= pwm_nxt;
          motor_l_en <= ({1'b0, pwm_nxt} < DUTY_C);
          motor_r_en <= ({1'b0, pwm_nxt} < DUTY_C);
          {motor_l_dir, motor_r_dir} <= dir_of(cmd_q);
          if (presc == PRESC_MAX) begin
            presc <= 16'd0;
            if (tick == TICK_MAX) begin
              state      <= DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              motor_l_en <= 1'b0;
              motor_r_en <= 1'b0;
            end else begin
              tick <= tick + 8'd1;
            end
          end else begin
            presc <= presc + 16'd1;
          end
        end
        DONE: begin
          state      <= IDLE;
          busy       <= 1'b0;
          motor_l_en <= 1'b0;
          motor_r_en <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          motor_l_en <= 1'b0;
          motor_r_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_movement_executor.sv
// Random and directed stimulus on three executors (DUTY 8/0/16) sharing inputs,
// compared every cycle against a command-level reference model.
module tb_movement_executor;
  localparam int CD = 4;
  localparam int MT = 3;
  localparam int L  = CD * MT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] movement_sel = 4'd0;
  logic [2:0] l_en, l_dir, r_en, r_dir, bsy, dn, err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic int duty_of(input int g);
    return (g == 0) ? 8 : ((g == 1) ? 0 : 16);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D = (g == 0) ? 8 : ((g == 1) ? 0 : 16);
    movement_executor #(.CLK_DIV(CD), .MOVE_TICKS(MT), .DUTY(D)) dut (
      .clk(clk), .rst(rst), .movement_sel(movement_sel),
      .motor_l_en(l_en[g]), .motor_l_dir(l_dir[g]),
      .motor_r_en(r_en[g]), .motor_r_dir(r_dir[g]),
      .busy(bsy[g]), .done(dn[g]), .cmd_err(err[g])
    );
  end

  // Reference: phase 0 idle, 1 running (m_k = cycles elapsed), 2 done pulse
  logic [1:0] dir_tab [5] = '{2'b00, 2'b11, 2'b00, 2'b10, 2'b01};
  int         m_ph  = 0;
  int         m_k   = 0;
  logic [1:0] m_dir = 2'b00;
  logic       m_err = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph <= 0; m_k <= 0; m_dir <= 2'b00; m_err <= 1'b0;
    end else begin
      m_err <= 1'b0;
      if (m_ph == 0) begin
        if (movement_sel >= 4'd1 && movement_sel <= 4'd4) begin
          m_ph  <= 1;
          m_k   <= 0;
          m_dir <= dir_tab[movement_sel];
        end else if (movement_sel > 4'd4) begin
          m_err <= 1'b1;
        end
      end else if (m_ph == 1) begin
        if (m_k == L - 1) m_ph <= 2;
        else m_k <= m_k + 1;
      end else begin
        m_ph <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    logic b, e;
    for (int g = 0; g < 3; g++) begin
      b = (m_ph == 1);
      e = b && ((m_k % 16) < duty_of(g));
      chk($sformatf("busy[%0d]", g), 32'(bsy[g]), 32'(b));
      chk($sformatf("done[%0d]", g), 32'(dn[g]), 32'(m_ph == 2));
      chk($sformatf("cmd_err[%0d]", g), 32'(err[g]), 32'(m_err));
      chk($sformatf("l_en[%0d]", g), 32'(l_en[g]), 32'(e));
      chk($sformatf("r_en[%0d]", g), 32'(r_en[g]), 32'(e));
      chk($sformatf("l_dir[%0d]", g), 32'(l_dir[g]), 32'(m_dir[1]));
      chk($sformatf("r_dir[%0d]", g), 32'(r_dir[g]), 32'(m_dir[0]));
    end
  endtask

  task automatic step(input logic [3:0] sel);
    @(negedge clk);
    check_all();
    movement_sel = sel;
  endtask

  // Async reset a couple of time units into a cycle; outputs must clear at once
  task automatic async_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("arst_out[%0d]", g),
          32'({l_en[g], l_dir[g], r_en[g], r_dir[g], bsy[g], dn[g], err[g]}), 32'd0);
    end
    @(negedge clk);
    check_all();
    movement_sel = 4'd0;
    step(4'd0);
    rst = 1'b0;
  endtask

  initial begin
    int nb, nd, r;
    movement_sel = 4'd0;
    step(4'd0);
    step(4'd0);
    rst = 1'b0;

    // Forward, single-cycle command
    step(4'd1);
    nb = 0; nd = 0;
    repeat (16) begin
      step(4'd0);
      nb += int'(bsy[0]);
      nd += int'(dn[0]);
    end
    chk("fwd_busy_cycles", 32'(nb), 32'(L));
    chk("fwd_done_pulses", 32'(nd), 32'd1);

    // Right then Left presented at the idle sample after DONE
    step(4'd3);
    repeat (13) step(4'd0);
    step(4'd4);
    repeat (15) step(4'd0);

    // Illegal code
    step(4'b1010);
    repeat (3) step(4'd0);

    // Reset on RUN cycle 5, aborted command must not resume
    step(4'd1);
    repeat (5) step(4'd0);
    async_reset();
    nd = 0;
    repeat (16) begin
      step(4'd0);
      nd += int'(dn[0]) + int'(bsy[0]);
    end
    chk("abort_no_resume", 32'(nd), 32'd0);

    // Input change during RUN is ignored; next command taken after DONE
    step(4'd2);
    step(4'd2);
    step(4'd2);
    step(4'd1);
    repeat (11) step(4'd1);
    repeat (16) step(4'd0);

    // Random traffic with occasional async reset
    repeat (1500) begin
      r = int'($urandom_range(0, 99));
      if (r < 60)      step(4'd0);
      else if (r < 85) step(4'($urandom_range(1, 4)));
      else             step(4'($urandom_range(5, 15)));
      if ($urandom_range(0, 199) == 0) async_reset();
    end
    repeat (20) step(4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/movement_executor.md
MOVEMENT_EXECUTOR -- requirements
Module: movement_executor

Interface
REQ-001 Parameter CLK_DIV, default 16, clk cycles per motion tick; legal range 1..65535.
REQ-002 Parameter MOVE_TICKS, default 8, motion ticks per executed command; legal range 1..255.
REQ-003 Parameter DUTY, default 12, PWM high count out of a 16-cycle period; legal range 0..16.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 movement_sel  input  4  command code: 0000 Idle, 0001 Forward, 0010 Back, 0011 Right, 0100 Left.
REQ-007 motor_l_en  output  1  left motor enable, PWM-gated.
REQ-008 motor_l_dir  output  1  left motor direction, 1 = forward.
REQ-009 motor_r_en  output  1  right motor enable, PWM-gated.
REQ-010 motor_r_dir  output  1  right motor direction, 1 = forward.
REQ-011 busy  output  1  high while a command executes.
REQ-012 done  output  1  one-cycle pulse on command completion.
REQ-013 cmd_err  output  1  one-cycle pulse on an illegal code sampled in IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 In IDLE the block SHALL sample movement_sel on every rising edge.
REQ-016 In IDLE, a legal nonzero code SHALL be latched into cmd_q, and the FSM SHALL enter RUN on that same edge.
REQ-017 In IDLE, code 0000 SHALL keep the FSM in IDLE with no other effect.
REQ-018 In IDLE, codes 0101..1111 SHALL keep the FSM in IDLE and assert cmd_err for exactly the next cycle.
REQ-019 On entry to RUN, the prescaler, tick counter and 4-bit PWM counter SHALL be cleared to 0.
REQ-020 In RUN, the prescaler SHALL count 0..CLK_DIV-1 and wrap; each wrap SHALL increment the tick counter.
REQ-021 RUN SHALL last exactly MOVE_TICKS*CLK_DIV cycles, after which the FSM SHALL enter DONE.
REQ-022 Changes on movement_sel during RUN or DONE SHALL be ignored.
REQ-023 The PWM counter SHALL increment every RUN cycle and wrap 15->0.
REQ-024 In RUN, motor_l_en and motor_r_en SHALL equal (pwm_cnt < DUTY) as a registered output; DUTY=0 SHALL mean always low and DUTY=16 always high.
REQ-025 In RUN, direction outputs SHALL be registered from cmd_q, as {l_dir, r_dir}: Forward 11, Back 00, Right 10, Left 01.
REQ-026 Outside RUN, motor_l_en and motor_r_en SHALL be 0 and both direction outputs SHALL hold their last value.
REQ-027 busy SHALL be 1 exactly during RUN cycles.
REQ-028 DONE SHALL last one cycle with done=1, busy=0 and motors disabled, then return to IDLE.
REQ-029 A new command SHALL be accepted at the first IDLE edge after DONE, giving back-to-back commands one idle sample cycle between RUN periods.
REQ-030 Any unreachable state encoding SHALL return to IDLE on the next edge with all enables low.

Reset
REQ-031 On rst=1, the FSM SHALL enter IDLE immediately, asynchronously, including in mid-RUN.
REQ-032 Reset values SHALL be: all outputs 0, cmd_q=0000, all counters 0.
REQ-033 An aborted command SHALL NOT resume after reset release and SHALL NOT produce done.
REQ-034 The first command SHALL be sampled on the first rising edge after rst deasserts.

Verification (bench overrides CLK_DIV=4, MOVE_TICKS=3, DUTY=8)
REQ-035 Forward: 0001 held one cycle in IDLE.
- busy=1 for 12 cycles; l_dir=r_dir=1.
- Enables high on RUN cycles 0-7, low on cycles 8-11.
- done pulses once; then IDLE.
REQ-036 Right, then Left, back-to-back: 0011 followed by 0100 presented at the IDLE after DONE.
- Two 12-cycle RUN periods, directions 10 then 01.
- Exactly one idle cycle between the DONE of the first command and the RUN of the second.
REQ-037 Illegal code: 1010 in IDLE.
- cmd_err=1 for one cycle; busy stays 0; motors off; no done.
REQ-038 Mid-command reset: rst asserted on RUN cycle 5.
- All outputs 0 asynchronously.
- After release with movement_sel=0000, FSM stays IDLE; no done pulse.
REQ-039 Input change during RUN: 0010 started, movement_sel switched to 0001 on cycle 3.
- Directions remain 00 for the full 12 cycles.
- The next command is sampled only after DONE.
REQ-040 Duty corners: repeat REQ-035 with DUTY=0 and DUTY=16.
- Enables always 0 and always 1 respectively.
- busy and done timing unchanged.
